// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: quad positions, activations per SRAM address and
// signed saturation bounds.
package cnn_pkg;

    localparam int ACT_PER_ADDR = 4;

    // 2x2 quad positions, in output order
    typedef enum logic [1:0] {
        PosLu = 2'd0,
        PosRu = 2'd1,
        PosLd = 2'd2,
        PosRd = 2'd3
    } quad_pos_e;

    function automatic longint sat_max(input int bw);
        return (longint'(1) <<< (bw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

endpackage

// File: rtl/resblock_quad_select.sv
// Picks one channel's 2x2 quad out of four bank words, applying the bank rotation
// given by map_type. Purely combinational.
module resblock_quad_select
    import cnn_pkg::*;
#(
    parameter int CH_NUM     = 24,
    parameter int BW_PER_ACT = 16
) (
    input  logic [1:0]                                   map_type,
    input  logic [6:0]                                   fmap_idx,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b3,
    output logic [ACT_PER_ADDR*BW_PER_ACT-1:0]           quad
);

    localparam int WORD_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;

    logic [WORD_W-1:0] bank [ACT_PER_ADDR];

    assign bank[0] = sram_rdata_b0;
    assign bank[1] = sram_rdata_b1;
    assign bank[2] = sram_rdata_b2;
    assign bank[3] = sram_rdata_b3;

    // Position p reads slot (3-p); slots count from the channel MSB, so slot (3-p)
    // sits p activations above the channel's LSB.
    always_comb begin
        quad = '0;
        for (int p = 0; p < ACT_PER_ADDR; p++) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (int'(fmap_idx) == c) begin
                    quad[p*BW_PER_ACT +: BW_PER_ACT] =
                        bank[2'(p) ^ map_type][((CH_NUM-1-c)*ACT_PER_ADDR + p)*BW_PER_ACT +:
                                               BW_PER_ACT];
                end
            end
        end
    end

endmodule

// File: rtl/resblock_skip_queue.sv
// Residual skip-connection queue: buffers forwarded activation quads and adds the
// oldest one to each incoming conv result with saturation and optional ReLU.
module resblock_skip_queue
    import cnn_pkg::*;
#(
    parameter int CH_NUM     = 24,
    parameter int BW_PER_ACT = 16,
    parameter int DEPTH      = 8
) (
    input  logic                                         clk,
    input  logic                                         srst,
    input  logic                                         push_valid,
    output logic                                         push_ready,
    input  logic [1:0]                                   map_type,
    input  logic [6:0]                                   fmap_idx,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]    sram_rdata_b3,
    input  logic                                         conv_valid,
    input  logic signed [BW_PER_ACT-1:0]                 conv_lu,
    input  logic signed [BW_PER_ACT-1:0]                 conv_ru,
    input  logic signed [BW_PER_ACT-1:0]                 conv_ld,
    input  logic signed [BW_PER_ACT-1:0]                 conv_rd,
    input  logic                                         add_en,
    input  logic                                         relu_en,
    output logic                                         out_valid,
    output logic signed [BW_PER_ACT-1:0]                 out_lu,
    output logic signed [BW_PER_ACT-1:0]                 out_ru,
    output logic signed [BW_PER_ACT-1:0]                 out_ld,
    output logic signed [BW_PER_ACT-1:0]                 out_rd,
    output logic [$clog2(DEPTH):0]                       count,
    output logic                                         err_ovf,
    output logic                                         err_udf,
    output logic                                         err_idx
);

    localparam int BW = BW_PER_ACT;
    localparam int QW = ACT_PER_ADDR * BW;
    localparam int PW = $clog2(DEPTH);

    localparam logic signed [BW:0] SAT_HI = (BW+1)'(sat_max(BW));
    localparam logic signed [BW:0] SAT_LO = (BW+1)'(sat_min(BW));

    logic [QW-1:0] sel_quad;
    logic [QW-1:0] head_quad;
    logic [QW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;

    logic full;
    logic empty;
    logic idx_ok;
    logic do_push;
    logic do_pop;

    logic                 out_valid_q;
    logic signed [BW-1:0] out_q      [ACT_PER_ADDR];
    logic signed [BW-1:0] conv_lane  [ACT_PER_ADDR];
    logic signed [BW-1:0] skip_lane  [ACT_PER_ADDR];
    logic signed [BW:0]   sum_lane   [ACT_PER_ADDR];
    logic signed [BW-1:0] res_lane   [ACT_PER_ADDR];

    logic err_ovf_q;
    logic err_udf_q;
    logic err_idx_q;

    resblock_quad_select #(
        .CH_NUM     (CH_NUM),
        .BW_PER_ACT (BW_PER_ACT)
    ) u_quad_select (
        .map_type      (map_type),
        .fmap_idx      (fmap_idx),
        .sram_rdata_b0 (sram_rdata_b0),
        .sram_rdata_b1 (sram_rdata_b1),
        .sram_rdata_b2 (sram_rdata_b2),
        .sram_rdata_b3 (sram_rdata_b3),
        .quad          (sel_quad)
    );

    assign full   = (count_q == (PW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign idx_ok = (int'(fmap_idx) < CH_NUM);

    // A pop frees the slot this cycle, so a push into a full queue may still land.
    // Pop needs a stored entry, so a same-cycle push never falls through.
    assign do_pop  = conv_valid && !empty;
    assign do_push = push_valid && idx_ok && (!full || do_pop);

    assign push_ready = !full;
    assign head_quad  = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    assign conv_lane[PosLu] = conv_lu;
    assign conv_lane[PosRu] = conv_ru;
    assign conv_lane[PosLd] = conv_ld;
    assign conv_lane[PosRd] = conv_rd;

    // Widen by one bit so the sum cannot wrap before saturation.
    always_comb begin
        for (int p = 0; p < ACT_PER_ADDR; p++) begin
            skip_lane[p] = '0;
            if (add_en && do_pop) begin
                skip_lane[p] = $signed(head_quad[p*BW +: BW]);
            end
            sum_lane[p] = (BW+1)'(conv_lane[p]) + (BW+1)'(skip_lane[p]);
            if (sum_lane[p] > SAT_HI) begin
                res_lane[p] = SAT_HI[BW-1:0];
            end else if (sum_lane[p] < SAT_LO) begin
                res_lane[p] = SAT_LO[BW-1:0];
            end else begin
                res_lane[p] = sum_lane[p][BW-1:0];
            end
            if (relu_en && res_lane[p][BW-1]) begin
                res_lane[p] = '0;
            end
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!srst && do_push) begin
            mem[wr_ptr_q] <= sel_quad;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
            err_idx_q   <= 1'b0;
            for (int p = 0; p < ACT_PER_ADDR; p++) begin
                out_q[p] <= '0;
            end
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
            out_valid_q <= conv_valid;
            err_idx_q   <= err_idx_q | (push_valid && !idx_ok);
            err_ovf_q   <= err_ovf_q | (push_valid && idx_ok && full && !do_pop);
            err_udf_q   <= err_udf_q | (conv_valid && empty);
            if (conv_valid) begin
                for (int p = 0; p < ACT_PER_ADDR; p++) begin
                    out_q[p] <= res_lane[p];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_lu    = out_q[PosLu];
    assign out_ru    = out_q[PosRu];
    assign out_ld    = out_q[PosLd];
    assign out_rd    = out_q[PosRd];
    assign count     = count_q;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;
    assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_resblock_skip_queue.sv
// Scoreboard bench for resblock_skip_queue: stimulus queues expected quads, a negedge
// monitor pops and compares them against out_*.
module tb_resblock_skip_queue;

    localparam int CH    = 24;
    localparam int BW    = 16;
    localparam int DEPTH = 8;
    localparam int WW    = CH * 4 * BW;

    logic                 clk = 1'b0;
    logic                 srst;
    logic                 push_valid;
    logic                 push_ready;
    logic [1:0]           map_type;
    logic [6:0]           fmap_idx;
    logic [WW-1:0]        sram_rdata_b0, sram_rdata_b1, sram_rdata_b2, sram_rdata_b3;
    logic                 conv_valid;
    logic signed [BW-1:0] conv_lu, conv_ru, conv_ld, conv_rd;
    logic                 add_en, relu_en;
    logic                 out_valid;
    logic signed [BW-1:0] out_lu, out_ru, out_ld, out_rd;
    logic [3:0]           count;
    logic                 err_ovf, err_udf, err_idx;

    resblock_skip_queue #(
        .CH_NUM     (CH),
        .BW_PER_ACT (BW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .map_type      (map_type),
        .fmap_idx      (fmap_idx),
        .sram_rdata_b0 (sram_rdata_b0),
        .sram_rdata_b1 (sram_rdata_b1),
        .sram_rdata_b2 (sram_rdata_b2),
        .sram_rdata_b3 (sram_rdata_b3),
        .conv_valid    (conv_valid),
        .conv_lu       (conv_lu),
        .conv_ru       (conv_ru),
        .conv_ld       (conv_ld),
        .conv_rd       (conv_rd),
        .add_en        (add_en),
        .relu_en       (relu_en),
        .out_valid     (out_valid),
        .out_lu        (out_lu),
        .out_ru        (out_ru),
        .out_ld        (out_ld),
        .out_rd        (out_rd),
        .count         (count),
        .err_ovf       (err_ovf),
        .err_udf       (err_udf),
        .err_idx       (err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] q;
        int          due;
    } exp_t;

    logic signed [BW-1:0] val [4][CH][4];
    logic [63:0]          mq [$];
    exp_t                 exp_q [$];
    logic [63:0]          last_out;
    bit                   m_ovf, m_udf, m_idx;
    bit                   mon_en = 1'b0;
    int                   cyc = 0;
    int                   n_tests = 0;
    int                   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WW-1:0] build_word(input int b);
        logic [WW-1:0] w;
        w = '0;
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < 4; s++)
                w[((CH-1-c)*4 + (3-s))*BW +: BW] = val[b][c][s];
        return w;
    endfunction

    function automatic logic [15:0] add_sat(input int a, input int b, input bit relu);
        int s;
        s = a + b;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic init_pattern();
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < CH; c++)
                for (int s = 0; s < 4; s++)
                    val[b][c][s] = 16'(b*4096 + c*16 + s);
    endtask

    task automatic check_state();
        chk("count", 64'(count), 64'(mq.size()));
        chk("push_ready", 64'(push_ready), 64'(mq.size() < DEPTH));
        chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
        chk("err_udf", 64'(err_udf), 64'(m_udf));
        chk("err_idx", 64'(err_idx), 64'(m_idx));
    endtask

    task automatic step(input bit pv, input int mt, input int idx, input bit cv,
                        input int c0, input int c1, input int c2, input int c3,
                        input bit ae, input bit re);
        int          cvals [4];
        logic [63:0] eq, sq, nq;
        bit          pop, push;
        cvals = '{c0, c1, c2, c3};
        push_valid = pv;
        map_type   = 2'(mt);
        fmap_idx   = 7'(idx);
        conv_valid = cv;
        conv_lu    = 16'(c0);
        conv_ru    = 16'(c1);
        conv_ld    = 16'(c2);
        conv_rd    = 16'(c3);
        add_en     = ae;
        relu_en    = re;
        sram_rdata_b0 = build_word(0);
        sram_rdata_b1 = build_word(1);
        sram_rdata_b2 = build_word(2);
        sram_rdata_b3 = build_word(3);

        pop  = cv && mq.size() > 0;
        push = pv && idx < CH && (mq.size() < DEPTH || pop);
        if (pv && idx >= CH) m_idx = 1'b1;
        if (pv && idx < CH && mq.size() == DEPTH && !pop) m_ovf = 1'b1;
        if (cv && mq.size() == 0) m_udf = 1'b1;
        if (cv) begin
            sq = (pop && ae) ? mq[0] : 64'd0;
            for (int p = 0; p < 4; p++)
                eq[p*16 +: 16] = add_sat(cvals[p], int'($signed(sq[p*16 +: 16])), re);
            exp_q.push_back('{eq, cyc + 1});
        end
        if (push) begin
            for (int p = 0; p < 4; p++)
                nq[p*16 +: 16] = val[p ^ mt][idx][3-p];
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(nq);

        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic push_q(input int mt, input int idx);
        step(1'b1, mt, idx, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Reset may be issued together with push and conv to show that it wins.
    task automatic do_reset(input bit pv, input bit cv);
        srst       = 1'b1;
        push_valid = pv;
        conv_valid = cv;
        fmap_idx   = 7'd1;
        @(posedge clk);
        #1;
        srst       = 1'b0;
        push_valid = 1'b0;
        conv_valid = 1'b0;
        exp_q.delete();
        mq.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_idx    = 1'b0;
        last_out = '0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", {out_rd, out_ld, out_ru, out_lu}, 64'd0);
        check_state();
    endtask

    logic [63:0] mon_act;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {out_rd, out_ld, out_ru, out_lu};
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h with nothing expected", mon_act);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_quad", mon_act, mon_e.q);
                    chk("out_latency", 64'(cyc), 64'(mon_e.due));
                    last_out = mon_e.q;
                end
            end else begin
                chk("out_hold", mon_act, last_out);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    mon_e = exp_q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_out: got out_valid=0 expected %0h", mon_e.q);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        srst = 1'b1;
        push_valid = 1'b0;
        conv_valid = 1'b0;
        map_type = '0;
        fmap_idx = '0;
        conv_lu = '0; conv_ru = '0; conv_ld = '0; conv_rd = '0;
        add_en = 1'b0;
        relu_en = 1'b0;
        init_pattern();
        sram_rdata_b0 = build_word(0);
        sram_rdata_b1 = build_word(1);
        sram_rdata_b2 = build_word(2);
        sram_rdata_b3 = build_word(3);
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);
        mon_en = 1'b1;

        // Rotated selection: map_type=2, channel 5
        push_q(2, 5);
        step(1'b0, 0, 0, 1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        @(negedge clk);
        chk("sel_valid", 64'(out_valid), 64'd1);
        chk("sel_lu", $unsigned(out_lu), 64'd8276);
        chk("sel_ru", $unsigned(out_ru), 64'd12372);
        chk("sel_ld", $unsigned(out_ld), 64'd84);
        chk("sel_rd", $unsigned(out_rd), 64'd4180);

        // Fill, overflow, push+pop while full, drain
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_q(i % 4, i);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(push_ready), 64'd0);
        push_q(0, 9);
        chk("ovf_flag", 64'(err_ovf), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        step(1'b1, 1, 10, 1'b1, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("pushpop_full_count", 64'(count), 64'd8);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 0, 1'b1, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("drained_count", 64'(count), 64'd0);

        // Underflow with simultaneous push: no fall-through
        do_reset(1'b0, 1'b0);
        step(1'b1, 0, 3, 1'b1, 10, -20, 30, -40, 1'b1, 1'b0);
        @(negedge clk);
        chk("udf_flag", 64'(err_udf), 64'd1);
        chk("udf_count", 64'(count), 64'd1);
        chk("udf_lu", $unsigned(out_lu), 64'h000A);
        chk("udf_ru", $unsigned(out_ru), 64'hFFEC);
        chk("udf_rd", $unsigned(out_rd), 64'hFFD8);
        step(1'b0, 0, 0, 1'b1, 0, 0, 0, 0, 1'b1, 1'b0);

        // Saturation and ReLU
        do_reset(1'b0, 1'b0);
        val[0][0][3] = 16'h7FF0;
        val[1][0][2] = 16'h8000;
        val[2][0][1] = 16'h8000;
        val[3][0][0] = 16'h0005;
        push_q(0, 0);
        push_q(0, 0);
        step(1'b0, 0, 0, 1'b1, 32, -1, -1, -7, 1'b1, 1'b0);
        @(negedge clk);
        chk("sat_hi", $unsigned(out_lu), 64'h7FFF);
        chk("sat_lo_ru", $unsigned(out_ru), 64'h8000);
        chk("sat_lo_ld", $unsigned(out_ld), 64'h8000);
        chk("sat_mid", $unsigned(out_rd), 64'hFFFE);
        step(1'b0, 0, 0, 1'b1, 32, -1, -1, -7, 1'b1, 1'b1);
        @(negedge clk);
        chk("relu_hi", $unsigned(out_lu), 64'h7FFF);
        chk("relu_ru", $unsigned(out_ru), 64'h0000);
        chk("relu_rd", $unsigned(out_rd), 64'h0000);
        push_q(0, 0);
        step(1'b0, 0, 0, 1'b1, 5, 6, 7, 8, 1'b0, 1'b0);
        @(negedge clk);
        chk("noadd_lu", $unsigned(out_lu), 64'h0005);
        chk("noadd_count", 64'(count), 64'd0);
        init_pattern();

        // Bad index, then reset mid-stream alongside push and conv
        do_reset(1'b0, 1'b0);
        push_q(0, 24);
        chk("idx_flag", 64'(err_idx), 64'd1);
        chk("idx_count", 64'(count), 64'd0);
        for (int i = 0; i < 5; i++) push_q(1, 20 + i % 4);
        chk("mid_count", 64'(count), 64'd5);
        do_reset(1'b1, 1'b1);
        chk("mid_rst_errs", {61'd0, err_ovf, err_udf, err_idx}, 64'd0);

        // Interleaved traffic wrapping the pointers several times
        for (int i = 0; i < 48; i++) begin
            val[$urandom_range(0, 3)][$urandom_range(0, CH-1)][$urandom_range(0, 3)] =
                16'($urandom_range(0, 65535));
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, CH-1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mq.size() > 0) step(1'b0, 0, 0, 1'b1, 100, -100, 7, -7, 1'b1, 1'b0);
        end
        idle();
        idle();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
